// File: rtl/ibex_pkg.sv
// Shared definitions for the iterative RV32M unit.
// Operator encodings and the ALU adder operand convention.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    // The LSB pair injects the carry-in: 1+0 adds, 1+1 adds one more.
    localparam logic ADDER_A_LSB     = 1'b1;
    localparam logic ADDER_ADD_B_LSB = 1'b0;
    localparam logic ADDER_SUB_B_LSB = 1'b1;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } adder_in_t;

    function automatic adder_in_t adder_add(
        input logic [31:0] x,
        input logic [31:0] y
    );
        adder_in_t r;
        r.a = {x, ADDER_A_LSB};
        r.b = {y, ADDER_ADD_B_LSB};
        return r;
    endfunction

    function automatic adder_in_t adder_sub(
        input logic [31:0] x,
        input logic [31:0] y
    );
        adder_in_t r;
        r.a = {x, ADDER_A_LSB};
        r.b = {~y, ADDER_SUB_B_LSB};
        return r;
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide borrowing the ALU adder.
// Works on operand magnitudes and fixes the sign in two final cycles.
module ibex_multdiv_iter
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic        mult_sel_i,
    input  logic [1:0]  operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        multdiv_sel_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] alu_adder_ext_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    typedef enum logic [2:0] {
        IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE
    } md_state_e;

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d, op_in;
    logic        mult_q, mult_d;
    logic [1:0]  sgn_q, sgn_d;
    logic        neg_q, neg_d;
    logic        carry_q, carry_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        valid_q;
    logic [31:0] result_q;

    adder_in_t   adder;
    logic [32:0] sum;
    logic        unused_ext_lsb;
    logic        accept;
    logic        rem_sel;
    logic [31:0] fix_tgt;
    logic        is_mull;
    logic        sign_a;
    logic        sign_b;
    logic        ge;
    logic        enter_done;
    logic [31:0] res_d;

    assign op_in          = md_op_e'(operator_i);
    assign sum            = alu_adder_ext_i[33:1];
    assign unused_ext_lsb = alu_adder_ext_i[0];
    assign accept         = (state_q == IDLE) && start_i && !kill_i;
    assign rem_sel        = !mult_q && (op_q == MD_OP_REM);
    assign fix_tgt        = rem_sel ? hi_q : lo_q;

    // Low product half is sign-agnostic, so MULL runs fully unsigned.
    assign is_mull = mult_sel_i && (op_in == MD_OP_MULL);
    assign sign_a  = !is_mull && signed_mode_i[0] && op_a_i[31];
    assign sign_b  = !is_mull && signed_mode_i[1] && op_b_i[31];

    always_comb begin
        adder = '0;
        unique case (state_q)
            ABS_A: adder = (sgn_q[0] && op_a_q[31]) ?
                adder_sub(32'd0, op_a_q) : adder_add(32'd0, op_a_q);
            ABS_B: adder = (sgn_q[1] && op_b_q[31]) ?
                adder_sub(32'd0, op_b_q) : adder_add(32'd0, op_b_q);
            ITER: adder = mult_q ?
                adder_add(hi_q, lo_q[0] ? op_a_q : 32'd0) :
                adder_sub({hi_q[30:0], lo_q[31]}, op_b_q);
            FIX_LO: adder = neg_q ?
                adder_sub(32'd0, fix_tgt) : adder_add(fix_tgt, 32'd0);
            FIX_HI: adder = (mult_q && neg_q) ?
                adder_add(~hi_q, {31'd0, carry_q}) :
                adder_add(hi_q, 32'd0);
            default: adder = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mult_d  = mult_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ge      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op_in;
                    mult_d = mult_sel_i;
                    sgn_d  = is_mull ? 2'b00 : signed_mode_i;
                    op_a_d = op_a_i;
                    op_b_d = op_b_i;
                    neg_d  = (!mult_sel_i && op_in == MD_OP_REM) ?
                             sign_a : (sign_a ^ sign_b);
                    if (!mult_sel_i && op_b_i == 32'd0) begin
                        hi_d    = op_a_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        state_d = ABS_A;
                    end
                end
            end
            ABS_A: begin
                op_a_d  = sum[31:0];
                state_d = ABS_B;
            end
            ABS_B: begin
                op_b_d  = sum[31:0];
                hi_d    = '0;
                lo_d    = mult_q ? sum[31:0] : op_a_q;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (mult_q) begin
                    hi_d = sum[32:1];
                    lo_d = {sum[0], lo_q[31:1]};
                end else begin
                    // A set remainder MSB means the 33-bit trial always fits.
                    ge   = hi_q[31] || sum[32];
                    hi_d = ge ? sum[31:0] : {hi_q[30:0], lo_q[31]};
                    lo_d = {lo_q[30:0], ge};
                end
                cnt_d = 5'(cnt_q + 5'd1);
                if (cnt_q == 5'd31) begin
                    state_d = FIX_LO;
                end
            end
            FIX_LO: begin
                if (rem_sel) begin
                    hi_d = sum[31:0];
                end else begin
                    lo_d = sum[31:0];
                end
                carry_d = sum[32];
                state_d = FIX_HI;
            end
            FIX_HI: begin
                if (mult_q) begin
                    hi_d = sum[31:0];
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign res_d = (op_d == MD_OP_MULL || op_d == MD_OP_DIV) ? lo_d : hi_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= MD_OP_MULL;
            mult_q   <= 1'b0;
            sgn_q    <= '0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mult_q   <= mult_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            valid_q  <= enter_done;
            if (enter_done) begin
                result_q <= res_d;
            end
        end
    end

    assign multdiv_sel_o   = (state_q != IDLE) && (state_q != DONE);
    assign alu_operand_a_o = adder.a;
    assign alu_operand_b_o = adder.b;
    assign busy_o          = (state_q != IDLE);
    assign valid_o         = valid_q;
    assign result_o        = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Bench for ibex_multdiv_iter: vector table, corner sequences and
// randomized ops against a 64-bit arithmetic reference model.
module tb_ibex_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic        mult_sel;
    logic [1:0]  operator;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        multdiv_sel;
    logic [32:0] alu_a;
    logic [32:0] alu_b;
    logic [33:0] alu_ext;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behaviour of the ALU's extended adder.
    assign alu_ext = {1'b0, alu_a} + {1'b0, alu_b};

    ibex_multdiv_iter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .kill_i          (kill),
        .mult_sel_i      (mult_sel),
        .operator_i      (operator),
        .signed_mode_i   (signed_mode),
        .op_a_i          (op_a),
        .op_b_i          (op_b),
        .multdiv_sel_o   (multdiv_sel),
        .alu_operand_a_o (alu_a),
        .alu_operand_b_o (alu_b),
        .alu_adder_ext_i (alu_ext),
        .busy_o          (busy),
        .valid_o         (valid),
        .result_o        (result)
    );

    typedef struct {
        logic        m;
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic m, input logic [1:0] op,
                                          input logic [1:0] mode,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = mode[0] ? longint'($signed(a)) : longint'({32'd0, a});
        sb = mode[1] ? longint'($signed(b)) : longint'({32'd0, b});
        if (m) begin
            p = 64'(sa * sb);
            return (op == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) begin
            return (op == 2'd3) ? a : 32'hFFFF_FFFF;
        end
        q = sa / sb;
        r = sa % sb;
        p = (op == 2'd3) ? 64'(r) : 64'(q);
        return p[31:0];
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic m, input logic [1:0] op,
                          input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          output logic [31:0] res, output int lat,
                          output int sel_err, output int tail_err);
        int exp_lat;
        exp_lat = (!m && b == 32'd0) ? 1 : 37;
        @(negedge clk);
        mult_sel = m; operator = op; signed_mode = mode;
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; sel_err = 0; tail_err = 0; res = '0;
        for (int c = 1; c <= 100; c++) begin
            if (multdiv_sel !== (c < exp_lat)) sel_err++;
            if (valid === 1'b1) begin
                lat = c;
                res = result;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (valid !== 1'b0 || result !== exp) tail_err = 1;
    endtask

    vec_t        tab[16];
    logic [31:0] res;
    logic [31:0] exp;
    int          lat, sel_err, tail_err, nvalid;
    logic        m;
    logic [1:0]  op, mode;
    logic [31:0] a, b;

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; mult_sel = 1'b0;
        operator = '0; signed_mode = '0; op_a = '0; op_b = '0;

        tab[0]  = '{1'b1, 2'd0, 2'b11, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 37};
        tab[1]  = '{1'b1, 2'd1, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 37};
        tab[2]  = '{1'b1, 2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 37};
        tab[3]  = '{1'b1, 2'd1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 37};
        tab[4]  = '{1'b0, 2'd2, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 37};
        tab[5]  = '{1'b0, 2'd3, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 37};
        tab[6]  = '{1'b0, 2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 37};
        tab[7]  = '{1'b0, 2'd3, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 37};
        tab[8]  = '{1'b0, 2'd2, 2'b00, 32'h1234, 32'd0, 32'hFFFFFFFF, 1};
        tab[9]  = '{1'b0, 2'd3, 2'b00, 32'h1234, 32'd0, 32'h1234, 1};
        tab[10] = '{1'b1, 2'd0, 2'b00, 32'd3, 32'd5, 32'd15, 37};
        tab[11] = '{1'b0, 2'd3, 2'b11, 32'h80000000, 32'd0, 32'h80000000, 1};
        tab[12] = '{1'b0, 2'd2, 2'b00, 32'd100, 32'd7, 32'd14, 37};
        tab[13] = '{1'b0, 2'd3, 2'b00, 32'd100, 32'd7, 32'd2, 37};
        tab[14] = '{1'b1, 2'd1, 2'b11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 37};
        tab[15] = '{1'b1, 2'd1, 2'b11, 32'hFFFFFFFF, 32'd0, 32'd0, 37};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_sel", 32'(multdiv_sel), 32'd0);
        chk("reset_opa", alu_a[31:0], 32'd0);
        chk("reset_opb", alu_b[31:0], 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        foreach (tab[i]) begin
            run_op(tab[i].m, tab[i].op, tab[i].mode, tab[i].a, tab[i].b,
                   tab[i].exp, res, lat, sel_err, tail_err);
            chk($sformatf("vec%0d_result", i), res, tab[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tab[i].lat));
            chk($sformatf("vec%0d_sel", i), 32'(sel_err), 32'd0);
            chk($sformatf("vec%0d_tail", i), 32'(tail_err), 32'd0);
        end

        // Kill in the middle of ITER: prior result must be held.
        run_op(1'b1, 2'd1, 2'b11, 32'h80000000, 32'h80000000,
               32'h40000000, res, lat, sel_err, tail_err);
        chk("prekill_result", res, 32'h40000000);
        @(negedge clk);
        mult_sel = 1'b0; operator = 2'd2; signed_mode = 2'b00;
        op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_valid", 32'(valid), 32'd0);
        chk("kill_result", result, 32'h40000000);
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1) nvalid++;
        end
        chk("kill_no_valid", 32'(nvalid), 32'd0);
        run_op(1'b1, 2'd0, 2'b00, 32'd3, 32'd5, 32'd15,
               res, lat, sel_err, tail_err);
        chk("postkill_mull", res, 32'd15);

        // Reset mid-ITER drops everything.
        @(negedge clk);
        mult_sel = 1'b1; operator = 2'd1; signed_mode = 2'b00;
        op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_sel", 32'(multdiv_sel), 32'd0);
        chk("midrst_opa", alu_a[31:0], 32'd0);
        rst = 1'b0;

        // start pulses while busy and in DONE are ignored.
        exp = model(1'b0, 2'd2, 2'b11, 32'hFFFF_F000, 32'd9);
        @(negedge clk);
        mult_sel = 1'b0; operator = 2'd2; signed_mode = 2'b11;
        op_a = 32'hFFFF_F000; op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvalid = 0; res = '0;
        for (int c = 1; c <= 60; c++) begin
            if (valid === 1'b1) begin
                nvalid++;
                res = result;
            end
            start = (c == 5 || c == 20 || c == 37);
            op_a = 32'(c);
            op_b = 32'd0;
            @(negedge clk);
        end
        chk("busy_start_count", 32'(nvalid), 32'd1);
        chk("busy_start_result", res, exp);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // kill beats start in IDLE.
        start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", 32'(busy), 32'd0);
        nvalid = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid === 1'b1) nvalid++;
        end
        chk("kill_start_valid", 32'(nvalid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            op = m ? {1'b0, 1'($urandom_range(0, 1))}
                   : {1'b1, 1'($urandom_range(0, 1))};
            mode = 2'($urandom_range(0, 3));
            a = rnd_val();
            b = rnd_val();
            exp = model(m, op, mode, a, b);
            run_op(m, op, mode, a, b, exp, res, lat, sel_err, tail_err);
            chk($sformatf("rnd%0d m%0d op%0d md%0d %h,%h", i, m, op, mode, a, b),
                res, exp);
            chk($sformatf("rnd%0d_latency", i), 32'(lat),
                (!m && b == 32'd0) ? 32'd1 : 32'd37);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
